// File: rtl/counter_checker.sv
// In-circuit monitor for the 4-bit enable/mode/parallel-load counter: runs a shadow
// model from the observed controls and reports mismatches, error/check counts and wraps.
module counter_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned CHK_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_rst,
    input  logic             mon_enb,
    input  logic             mon_modo,
    input  logic [WIDTH-1:0] mon_data,
    input  logic [WIDTH-1:0] mon_q,
    output logic [WIDTH-1:0] exp_q,
    output logic             mismatch,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count,
    output logic [CHK_W-1:0] chk_count,
    output logic             wrap,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'b00,
        ST_CHECK  = 2'b01,
        ST_FAIL   = 2'b10
    } state_e;

    localparam logic [WIDTH-1:0] Q_MAX   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [CHK_W-1:0] CHK_MAX = '1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   model_q, model_d;
    logic               mismatch_q, mismatch_d;
    logic               err_flag_q, err_flag_d;
    logic               wrap_q, wrap_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CHK_W-1:0]   chk_cnt_q, chk_cnt_d;

    logic               miss;
    logic               counting;
    logic               sync_evt;
    logic [WIDTH-1:0]   base;
    logic [WIDTH-1:0]   next_val;

    // After a mismatch the model restarts from what the counter actually shows,
    // so a single fault produces one error rather than a cascade.
    always_comb begin
        miss     = (state_q == ST_CHECK) && (mon_q != model_q);
        base     = miss ? mon_q : model_q;
        counting = !mon_rst && mon_enb && !mon_modo;
        sync_evt = mon_rst || (mon_enb && mon_modo);

        if (mon_rst)       next_val = '0;
        else if (!mon_enb) next_val = base;
        else if (mon_modo) next_val = mon_data;
        else               next_val = base + WIDTH'(1);
    end

    // NOTE: every variable gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        model_d    = model_q;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        chk_cnt_d  = chk_cnt_q;

        unique case (state_q)
            ST_UNSYNC: begin
                model_d = next_val;
                if (sync_evt) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (chk_cnt_q != CHK_MAX) chk_cnt_d = chk_cnt_q + CHK_W'(1);
                if (miss) begin
                    mismatch_d = 1'b1;
                    err_flag_d = 1'b1;
                    if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
                end
                if (miss && STOP_ON_ERR) begin
                    state_d = ST_FAIL;
                end else begin
                    model_d = next_val;
                    wrap_d  = counting && (base == Q_MAX);
                end
            end
            ST_FAIL: begin
                // Everything frozen; only rst leaves this state.
            end
            default: state_d = ST_UNSYNC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_UNSYNC;
            model_q    <= '0;
            mismatch_q <= 1'b0;
            err_flag_q <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= '0;
            chk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            model_q    <= model_d;
            mismatch_q <= mismatch_d;
            err_flag_q <= err_flag_d;
            wrap_q     <= wrap_d;
            err_cnt_q  <= err_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
        end
    end

    assign exp_q     = model_q;
    assign mismatch  = mismatch_q;
    assign err_flag  = err_flag_q;
    assign err_count = err_cnt_q;
    assign chk_count = chk_cnt_q;
    assign wrap      = wrap_q;
    assign state     = state_q;

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: three instances (resync, stop-on-error,
// 2-bit error counter) watch one shared stimulus stream.
module tb_counter_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       mon_rst = 1'b0, mon_enb = 1'b0, mon_modo = 1'b0;
    logic [3:0] mon_data = '0, mon_q = '0;

    logic [3:0]  exp_q_a, exp_q_b, exp_q_c;
    logic        mm_a, mm_b, mm_c, flag_a, flag_b, flag_c, wrap_a, wrap_b, wrap_c;
    logic [7:0]  ecnt_a, ecnt_b;
    logic [1:0]  ecnt_c;
    logic [15:0] ccnt_a, ccnt_b, ccnt_c;
    logic [1:0]  st_a, st_b, st_c;

    counter_checker #(.WIDTH(4), .ERR_W(8), .CHK_W(16), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_enb(mon_enb), .mon_modo(mon_modo),
        .mon_data(mon_data), .mon_q(mon_q), .exp_q(exp_q_a), .mismatch(mm_a),
        .err_flag(flag_a), .err_count(ecnt_a), .chk_count(ccnt_a), .wrap(wrap_a), .state(st_a));

    counter_checker #(.WIDTH(4), .ERR_W(8), .CHK_W(16), .STOP_ON_ERR(1'b1)) dut_b (
        .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_enb(mon_enb), .mon_modo(mon_modo),
        .mon_data(mon_data), .mon_q(mon_q), .exp_q(exp_q_b), .mismatch(mm_b),
        .err_flag(flag_b), .err_count(ecnt_b), .chk_count(ccnt_b), .wrap(wrap_b), .state(st_b));

    counter_checker #(.WIDTH(4), .ERR_W(2), .CHK_W(16), .STOP_ON_ERR(1'b0)) dut_c (
        .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_enb(mon_enb), .mon_modo(mon_modo),
        .mon_data(mon_data), .mon_q(mon_q), .exp_q(exp_q_c), .mismatch(mm_c),
        .err_flag(flag_c), .err_count(ecnt_c), .chk_count(ccnt_c), .wrap(wrap_c), .state(st_c));

    typedef struct {
        int st;
        int exp_q;
        int mm;
        int flag;
        int ecnt;
        int ccnt;
        int wrap;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
        mdl_t c;
    } sb_t;

    sb_t        sb[$];
    mdl_t       mdl_a, mdl_b, mdl_c;
    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    logic [3:0] cnt = '0;

    // Expected checker behaviour for one clock edge: 0 UNSYNC, 1 CHECK, 2 FAIL.
    function automatic mdl_t model_next(mdl_t m, bit stop, int emax,
                                        bit r, bit mr, bit en, bit mo, int d, int q);
        mdl_t n;
        int   b;
        bit   bad;
        n      = m;
        n.mm   = 0;
        n.wrap = 0;
        if (r) begin
            n.st = 0; n.exp_q = 0; n.flag = 0; n.ecnt = 0; n.ccnt = 0;
            return n;
        end
        if (m.st == 2) return n;
        bad = (m.st == 1) && (q != m.exp_q);
        if (m.st == 1) begin
            if (n.ccnt < 65535) n.ccnt = n.ccnt + 1;
            if (bad) begin
                n.mm = 1;
                n.flag = 1;
                if (n.ecnt < emax) n.ecnt = n.ecnt + 1;
                if (stop) begin
                    n.st = 2;
                    return n;
                end
            end
        end
        b = bad ? q : m.exp_q;
        if (mr)       n.exp_q = 0;
        else if (!en) n.exp_q = b;
        else if (mo)  n.exp_q = d;
        else          n.exp_q = (b + 1) % 16;
        if (m.st == 1 && !mr && en && !mo && b == 15) n.wrap = 1;
        if (m.st == 0 && (mr || (en && mo))) n.st = 1;
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL edge %0d %s: got %0d expected %0d", edge_n, name, act, exp);
        end
    endtask

    task automatic cmp_inst(input string tag, input mdl_t e, input int st, input int xq,
                            input int mm, input int fl, input int ec, input int cc, input int wr);
        check({tag, ".state"},     st, e.st);
        check({tag, ".exp_q"},     xq, e.exp_q);
        check({tag, ".mismatch"},  mm, e.mm);
        check({tag, ".err_flag"},  fl, e.flag);
        check({tag, ".err_count"}, ec, e.ecnt);
        check({tag, ".chk_count"}, cc, e.ccnt);
        check({tag, ".wrap"},      wr, e.wrap);
    endtask

    // Monitor: every edge that has a queued expectation is compared just after the edge.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            edge_n++;
            cmp_inst("A", e.a, int'(st_a), int'(exp_q_a), int'(mm_a), int'(flag_a),
                     int'(ecnt_a), int'(ccnt_a), int'(wrap_a));
            cmp_inst("B", e.b, int'(st_b), int'(exp_q_b), int'(mm_b), int'(flag_b),
                     int'(ecnt_b), int'(ccnt_b), int'(wrap_b));
            cmp_inst("C", e.c, int'(st_c), int'(exp_q_c), int'(mm_c), int'(flag_c),
                     int'(ecnt_c), int'(ccnt_c), int'(wrap_c));
        end
    end

    task automatic drive(input bit r, input bit mr, input bit en, input bit mo,
                         input logic [3:0] d, input logic [3:0] q);
        sb_t e;
        @(negedge clk);
        rst = r; mon_rst = mr; mon_enb = en; mon_modo = mo; mon_data = d; mon_q = q;
        mdl_a = model_next(mdl_a, 1'b0, 255, r, mr, en, mo, int'(d), int'(q));
        mdl_b = model_next(mdl_b, 1'b1, 255, r, mr, en, mo, int'(d), int'(q));
        mdl_c = model_next(mdl_c, 1'b0, 3,   r, mr, en, mo, int'(d), int'(q));
        e.a = mdl_a; e.b = mdl_b; e.c = mdl_c;
        sb.push_back(e);
    endtask

    // A correctly behaving counter presents cnt and then updates it.
    task automatic good(input bit mr, input bit en, input bit mo, input logic [3:0] d);
        drive(1'b0, mr, en, mo, d, cnt);
        if (mr)      cnt = 4'd0;
        else if (en) cnt = mo ? d : cnt + 4'd1;
    endtask

    initial begin
        mdl_a = '{default: 0};
        mdl_b = '{default: 0};
        mdl_c = '{default: 0};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        // Sync via mon_rst, then 20 counts through one wrap.
        good(1'b1, 1'b0, 1'b0, 4'd0);
        repeat (20) good(1'b0, 1'b1, 1'b0, 4'd0);

        // Load 6, count twice, hold for 5 cycles.
        good(1'b0, 1'b1, 1'b1, 4'd6);
        repeat (2) good(1'b0, 1'b1, 1'b0, 4'd0);
        repeat (5) good(1'b0, 1'b0, 1'b0, 4'd0);

        // Load 4, then the counter jumps to 9 and continues from there.
        good(1'b0, 1'b1, 1'b1, 4'd4);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9);
        cnt = 4'd10;
        repeat (2) good(1'b0, 1'b1, 1'b0, 4'd0);

        // Garbage outputs while holding: one error per edge, then recovery.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2);
        repeat (2) good(1'b0, 1'b0, 1'b0, 4'd0);

        // rst wins over active monitor inputs; counting alone never syncs.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd7);
        cnt = 4'd0;
        repeat (5) good(1'b0, 1'b1, 1'b0, 4'd0);

        // Load 15 then load 0: no wrap. Then mon_rst with a wrong Q and a load request.
        good(1'b0, 1'b1, 1'b1, 4'd15);
        good(1'b0, 1'b1, 1'b1, 4'd0);
        good(1'b0, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd5);
        cnt = 4'd0;
        repeat (2) good(1'b0, 1'b1, 1'b0, 4'd0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
